// File: rtl/lut_sub_i8_i8_i8.sv
// 8-bit two's-complement subtractor y = a - b built from chained per-bit LUT cells.
// Optional output register enabled by defining LUT_SUB_REG_OUT_EN.

module lut_sub_i8_i8_i8_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   // Truth tables indexed by {a, b, c}.
   // The inversion of b is folded into the tables:
   //   sum   = a ^ ~b ^ c
   //   carry = maj(a, ~b, c)
   localparam logic [7:0] LUT_SUM   = 8'h69;
   localparam logic [7:0] LUT_CARRY = 8'hB2;

   logic [2:0] w_idx;

   assign w_idx = {i_a, i_b, i_c};
   assign o_s   = LUT_SUM[w_idx];
   assign o_c   = LUT_CARRY[w_idx];
endmodule

module lut_sub_i8_i8_i8 #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   if (WIDTH != 8) begin : g_width_check
      $error("lut_sub_i8_i8_i8 supports only WIDTH == 8");
   end

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_diff;
   logic             w_unused;

   // A carry-in of 1 completes the two's-complement negation of b.
   assign w_carry[0] = 1'b1;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      lut_sub_i8_i8_i8_cell u_cell (
         .i_a (a[gi]),
         .i_b (b[gi]),
         .i_c (w_carry[gi]),
         .o_s (w_diff[gi]),
         .o_c (w_carry[gi+1])
      );
   end

`ifdef LUT_SUB_REG_OUT_EN
   logic [WIDTH-1:0] r_y;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_y <= '0;
      end else begin
         r_y <= w_diff;
      end
   end

   assign y = r_y;
`else
   assign y = w_diff;
`endif

   // The final carry-out is deliberately not exported.
   // clock and reset are idle in the combinational build.
   assign w_unused = ^{clock, reset, w_carry[WIDTH]};
endmodule

// File: tb/tb_lut_sub_i8_i8_i8.sv
// Directed and exhaustive check of lut_sub_i8_i8_i8.
// Handles both the combinational and the LUT_SUB_REG_OUT_EN builds.

module tb_lut_sub_i8_i8_i8;
   logic       clock;
   logic       reset;
   logic       clk_en;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] y;
   int         total;
   int         bad;

   lut_sub_i8_i8_i8 dut (
      .clock (clock),
      .reset (reset),
      .a     (a),
      .b     (b),
      .y     (y)
   );

   initial clock = 1'b0;

   always begin
      #5;
      if (clk_en) clock = ~clock;
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive on the falling edge.
   // Sample 1 time unit after the result is due.
   task automatic apply(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] exp);
      @(negedge clock);
      a = va;
      b = vb;
`ifdef LUT_SUB_REG_OUT_EN
      @(posedge clock);
`endif
      #1;
      check(tag, y, exp);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      clk_en = 1'b1;
      reset  = 1'b0;
      a      = 8'h01;
      b      = 8'hFD;
      #12;
`ifdef LUT_SUB_REG_OUT_EN
      check("rst_hold", y, 8'h00);
`else
      check("rst_comb", y, 8'h04);
`endif
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("rst_release", y, 8'h04);

      apply("neg_ovf", 8'h80, 8'h01, 8'h7F);
      apply("pos_ovf", 8'h7F, 8'hFF, 8'h80);
      apply("zero_m1", 8'h00, 8'h01, 8'hFF);
      apply("self_sub", 8'h55, 8'h55, 8'h00);
      apply("ff_m0", 8'hFF, 8'h00, 8'hFF);
      apply("small", 8'h10, 8'h01, 8'h0F);

`ifdef LUT_SUB_REG_OUT_EN
      // Asynchronous reset mid-stream.
      #2;
      reset = 1'b0;
      #1;
      check("async_rst", y, 8'h00);
      @(negedge clock);
      check("async_rst_hold", y, 8'h00);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("async_rel", y, 8'h0F);
`else
      // Stop the clock and toggle reset; output must track inputs only.
      @(negedge clock);
      clk_en = 1'b0;
      a = 8'h09;
      b = 8'h02;
      #1;
      check("noclk", y, 8'h07);
      reset = 1'b0;
      #3;
      check("noclk_rst_lo", y, 8'h07);
      reset = 1'b1;
      #3;
      check("noclk_rst_hi", y, 8'h07);
      clk_en = 1'b1;
`endif

      for (int ai = 0; ai < 256; ai++) begin
         for (int bi = 0; bi < 256; bi++) begin
            logic [7:0] va;
            logic [7:0] vb;
            logic [7:0] exp;
            va  = 8'(ai);
            vb  = 8'(bi);
            exp = 8'((ai - bi) & 255);
            apply("sweep", va, vb, exp);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
